// File: rtl/stu_pkg.sv
// rtl/stu_pkg.sv - Core-wide architectural widths.
package stu_pkg;

    localparam int XLEN = 32;

endpackage

// File: rtl/supernova_alu_issue_queue_pkg.sv
// rtl/supernova_alu_issue_queue_pkg.sv - ALU issue queue defaults and wakeup helper.
package supernova_alu_issue_queue_pkg;

    import supernova_pkg::*;

    localparam int IQ_DEPTH_DEFAULT  = ALU_IQ_DEPTH;
    localparam int IQ_NUM_WB_DEFAULT = 2;

    // A broadcast port hits a waiting source when it is valid and carries its tag.
    function automatic logic tag_hit(
        input logic                     wb_valid,
        input logic [GPR_TAG_WIDTH-1:0] wb_tag,
        input logic [GPR_TAG_WIDTH-1:0] src_tag
    );
        return wb_valid && (wb_tag == src_tag);
    endfunction

endpackage

// File: rtl/supernova_pkg.sv
// rtl/supernova_pkg.sv - Supernova backend shared types and widths.
package supernova_pkg;

    import stu_pkg::*;

    localparam int GPR_TAG_WIDTH = 6;
    localparam int ROB_IDX_WIDTH = 5;
    localparam int ALU_IQ_DEPTH  = 8;

    typedef struct packed {
        logic [31:0]              instr;
        logic [XLEN-1:0]          pc;
        logic [GPR_TAG_WIDTH-1:0] src1_tag;
        logic                     src1_ready;
        logic [XLEN-1:0]          src1_data;
        logic [GPR_TAG_WIDTH-1:0] src2_tag;
        logic                     src2_ready;
        logic [XLEN-1:0]          src2_data;
        logic [GPR_TAG_WIDTH-1:0] rd_phys_tag;
        logic [ROB_IDX_WIDTH-1:0] rob_idx;
    } rs_entry_t;

endpackage

// File: rtl/supernova_alu_issue_queue_if.sv
// rtl/supernova_alu_issue_queue_if.sv - Dispatch, wakeup and issue bundle of the ALU issue queue.
// Signals: dispatch_valid_in/dispatch_entry_in/dispatch_ready_out (dispatch handshake),
// wb_valid_in/wb_gpr_tag_in/wb_data_in (writeback broadcasts), flush_in,
// req_valid_out/req_entry_out (issue to ALU), occupancy_out.
// Modports: slave = the queue, master = dispatch/writeback/ALU side.
interface supernova_alu_issue_queue_if
    import supernova_pkg::*, stu_pkg::*, supernova_alu_issue_queue_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH_DEFAULT,
    parameter int NUM_WB = IQ_NUM_WB_DEFAULT
) ();

    logic                                   dispatch_valid_in;
    rs_entry_t                              dispatch_entry_in;
    logic                                   dispatch_ready_out;
    logic [NUM_WB-1:0]                      wb_valid_in;
    logic [NUM_WB-1:0][GPR_TAG_WIDTH-1:0]   wb_gpr_tag_in;
    logic [NUM_WB-1:0][XLEN-1:0]            wb_data_in;
    logic                                   flush_in;
    logic                                   req_valid_out;
    rs_entry_t                              req_entry_out;
    logic [$clog2(DEPTH+1)-1:0]             occupancy_out;

    modport slave (
        input  dispatch_valid_in, dispatch_entry_in,
        input  wb_valid_in, wb_gpr_tag_in, wb_data_in, flush_in,
        output dispatch_ready_out, req_valid_out, req_entry_out, occupancy_out
    );

    modport master (
        output dispatch_valid_in, dispatch_entry_in,
        output wb_valid_in, wb_gpr_tag_in, wb_data_in, flush_in,
        input  dispatch_ready_out, req_valid_out, req_entry_out, occupancy_out
    );

endinterface

// File: rtl/supernova_oldest_ready_select.sv
// rtl/supernova_oldest_ready_select.sv - Age-matrix oldest-candidate picker.
// Ports: cand (candidate vector), older (older[i][j]=1: i dispatched before j),
// grant (one-hot winner), any (at least one candidate).
module supernova_oldest_ready_select #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]            cand,
    input  logic [DEPTH-1:0][DEPTH-1:0] older,
    output logic [DEPTH-1:0]            grant,
    output logic                        any
);

    logic blocked;

    // An entry wins when no other candidate is older than it. Rows of
    // non-candidates are masked, so stale age bits of freed slots are harmless.
    always_comb begin
        grant   = '0;
        blocked = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            blocked = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                if (cand[k] && older[k][i]) begin
                    blocked = 1'b1;
                end
            end
            grant[i] = cand[i] && !blocked;
        end
    end

    assign any = |cand;

endmodule

// File: rtl/supernova_alu_issue_queue.sv
// rtl/supernova_alu_issue_queue.sv - Data-capture issue queue in front of the 1-cycle ALU.
// Ports: clk, rst (async, active-high), iq (slave modport: dispatch handshake,
// writeback broadcasts, flush, issue request, occupancy).
module supernova_alu_issue_queue
    import supernova_pkg::*, stu_pkg::*, supernova_alu_issue_queue_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH_DEFAULT,
    parameter int NUM_WB = IQ_NUM_WB_DEFAULT
) (
    input logic                        clk,
    input logic                        rst,
    supernova_alu_issue_queue_if.slave iq
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]            valid_q;
    rs_entry_t                   entry_q [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] older_q;
    logic [OCC_W-1:0]            occ_q;

    rs_entry_t        woken [DEPTH];
    rs_entry_t        disp_woken;
    rs_entry_t        issue_entry;
    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] grant;
    logic [DEPTH-1:0] free_oh;
    logic             any_cand;
    logic             accept;
    logic             issue;
    logic             wb_dup;

    // Captures broadcast data into any source still waiting; the lowest port wins.
    function automatic rs_entry_t wake(
        input rs_entry_t                            e,
        input logic [NUM_WB-1:0]                    v,
        input logic [NUM_WB-1:0][GPR_TAG_WIDTH-1:0] t,
        input logic [NUM_WB-1:0][XLEN-1:0]          d
    );
        rs_entry_t r;
        logic      hit1;
        logic      hit2;
        r    = e;
        hit1 = e.src1_ready;
        hit2 = e.src2_ready;
        for (int p = 0; p < NUM_WB; p++) begin
            if (!hit1 && tag_hit(v[p], t[p], e.src1_tag)) begin
                r.src1_ready = 1'b1;
                r.src1_data  = d[p];
                hit1         = 1'b1;
            end
            if (!hit2 && tag_hit(v[p], t[p], e.src2_tag)) begin
                r.src2_ready = 1'b1;
                r.src2_data  = d[p];
                hit2         = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = wake(entry_q[i], iq.wb_valid_in, iq.wb_gpr_tag_in, iq.wb_data_in);
            cand[i]  = valid_q[i] && entry_q[i].src1_ready && entry_q[i].src2_ready;
        end
        // The dispatching op snoops the same broadcasts so it cannot miss a wakeup.
        disp_woken = wake(iq.dispatch_entry_in, iq.wb_valid_in, iq.wb_gpr_tag_in, iq.wb_data_in);
    end

    supernova_oldest_ready_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .cand  (cand),
        .older (older_q),
        .grant (grant),
        .any   (any_cand)
    );

    // Lowest clear bit of valid_q, as a one-hot; zero when the queue is full.
    assign free_oh = ~valid_q & (valid_q + DEPTH'(1));

    assign iq.dispatch_ready_out = (occ_q < OCC_W'(DEPTH));
    assign accept                = iq.dispatch_valid_in && iq.dispatch_ready_out && !iq.flush_in;
    assign issue                 = any_cand && !iq.flush_in;

    always_comb begin
        issue_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                issue_entry = entry_q[i];
            end
        end
    end

    assign iq.req_valid_out = issue;
    assign iq.req_entry_out = issue_entry;
    assign iq.occupancy_out = occ_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            older_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else if (iq.flush_in) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            // grant is empty when nothing issues, so it can clear unconditionally.
            valid_q <= (valid_q & ~grant) | (accept ? free_oh : '0);
            occ_q   <= occ_q + OCC_W'(accept) - OCC_W'(issue);
            for (int i = 0; i < DEPTH; i++) begin
                if (accept && free_oh[i]) begin
                    entry_q[i] <= disp_woken;
                    older_q[i] <= '0;
                    // Everything already resident is older than the newcomer.
                    for (int k = 0; k < DEPTH; k++) begin
                        older_q[k][i] <= valid_q[k];
                    end
                end else if (valid_q[i]) begin
                    entry_q[i] <= woken[i];
                end
            end
        end
    end

    always_comb begin
        wb_dup = 1'b0;
        for (int p = 0; p < NUM_WB; p++) begin
            for (int q = p + 1; q < NUM_WB; q++) begin
                if (iq.wb_valid_in[p] && iq.wb_valid_in[q] &&
                    (iq.wb_gpr_tag_in[p] == iq.wb_gpr_tag_in[q])) begin
                    wb_dup = 1'b1;
                end
            end
        end
    end

    // Two ports broadcasting one tag means two producers of one physical register.
    a_wb_unique_tag: assert property (@(posedge clk) disable iff (rst) !wb_dup)
        else $error("writeback ports broadcast the same tag");

endmodule

// File: tb/tb_supernova_alu_issue_queue.sv
// tb/tb_supernova_alu_issue_queue.sv - Scoreboard bench for the ALU issue queue.
module tb_supernova_alu_issue_queue;

    import stu_pkg::*;
    import supernova_pkg::*;

    localparam int DEPTH  = 8;
    localparam int NUM_WB = 2;

    typedef struct {
        int              rob;
        logic [XLEN-1:0] d1;
        logic [XLEN-1:0] d2;
        int              cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    supernova_alu_issue_queue_if #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) iq_if ();

    supernova_alu_issue_queue #(.DEPTH(DEPTH), .NUM_WB(NUM_WB)) dut (
        .clk (clk),
        .rst (rst),
        .iq  (iq_if)
    );

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    function automatic rs_entry_t mk(input int rob, input int t1, input logic r1, input logic [XLEN-1:0] d1,
                                     input int t2, input logic r2, input logic [XLEN-1:0] d2);
        rs_entry_t e;
        e             = '0;
        e.instr       = 32'h0000_0033;
        e.pc          = XLEN'(32'h1000 + rob * 4);
        e.src1_tag    = GPR_TAG_WIDTH'(t1);
        e.src1_ready  = r1;
        e.src1_data   = d1;
        e.src2_tag    = GPR_TAG_WIDTH'(t2);
        e.src2_ready  = r2;
        e.src2_data   = d2;
        e.rd_phys_tag = GPR_TAG_WIDTH'(rob + 2);
        e.rob_idx     = ROB_IDX_WIDTH'(rob);
        return e;
    endfunction

    task automatic push_exp(input int rob, input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2, input int c);
        exp_t e;
        e.rob = rob; e.d1 = d1; e.d2 = d2; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic check_issue();
        exp_t e;
        if (iq_if.req_valid_out === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got rob_idx=%0d in cycle %0d, required no issue",
                         iq_if.req_entry_out.rob_idx, cyc);
            end else begin
                e = exp_q.pop_front();
                if (iq_if.req_entry_out.rob_idx !== ROB_IDX_WIDTH'(e.rob) ||
                    iq_if.req_entry_out.src1_data !== e.d1 ||
                    iq_if.req_entry_out.src2_data !== e.d2 || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL issue: got rob=%0d s1=%h s2=%h cycle=%0d, required rob=%0d s1=%h s2=%h cycle=%0d",
                             iq_if.req_entry_out.rob_idx, iq_if.req_entry_out.src1_data,
                             iq_if.req_entry_out.src2_data, cyc, e.rob, e.d1, e.d2, e.cyc);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_issue();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic dispatch(input rs_entry_t e);
        iq_if.dispatch_valid_in = 1'b1;
        iq_if.dispatch_entry_in = e;
        tick();
        iq_if.dispatch_valid_in = 1'b0;
    endtask

    task automatic broadcast(input int port, input int tag, input logic [XLEN-1:0] data);
        iq_if.wb_valid_in[port]   = 1'b1;
        iq_if.wb_gpr_tag_in[port] = GPR_TAG_WIDTH'(tag);
        iq_if.wb_data_in[port]    = data;
        tick();
        iq_if.wb_valid_in = '0;
    endtask

    task automatic do_flush();
        iq_if.flush_in = 1'b1;
        tick();
        iq_if.flush_in = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d issues outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_occ(input string name, input int occ);
        checks++;
        if (iq_if.occupancy_out !== 4'(occ)) begin
            errors++;
            $display("FAIL %s_occupancy: got %0d, required %0d", name, iq_if.occupancy_out, occ);
        end
    endtask

    task automatic check_ready(input string name, input logic rdy);
        checks++;
        if (iq_if.dispatch_ready_out !== rdy) begin
            errors++;
            $display("FAIL %s_dispatch_ready: got %b, required %b", name, iq_if.dispatch_ready_out, rdy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iq_if.dispatch_valid_in = 1'b0;
        iq_if.dispatch_entry_in = '0;
        iq_if.wb_valid_in       = '0;
        iq_if.wb_gpr_tag_in     = '0;
        iq_if.wb_data_in        = '0;
        iq_if.flush_in          = 1'b0;
        tick();
        tick();
        checks++;
        if (iq_if.req_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_valid: got %b, required 0", iq_if.req_valid_out);
        end
        checks++;
        if (iq_if.req_entry_out !== '0) begin
            errors++;
            $display("FAIL reset_req_entry: got %h, required 0", iq_if.req_entry_out);
        end
        check_ready("reset", 1'b1);
        check_occ("reset", 0);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_issue();
        rs_entry_t e;
        e       = mk(3, 1, 1'b1, 32'd10, 2, 1'b1, 32'd20);
        e.instr = 32'h0050_0093;
        push_exp(3, 32'd10, 32'd20, cyc + 1);
        dispatch(e);
        check_occ("single_after_dispatch", 1);
        tick();
        check_occ("single_after_issue", 0);
        drain("single");
    endtask

    task automatic test_wakeup();
        dispatch(mk(4, 3, 1'b1, 32'd5, 17, 1'b0, 32'd0));
        repeat (3) tick();
        check_occ("wakeup_waiting", 1);
        push_exp(4, 32'd5, 32'hDEAD, cyc + 1);
        broadcast(1, 17, 32'hDEAD);
        drain("wakeup");
    endtask

    task automatic test_oldest();
        dispatch(mk(10, 20, 1'b0, 0, 1, 1'b1, 32'h1));
        dispatch(mk(11, 21, 1'b0, 0, 1, 1'b1, 32'h1));
        dispatch(mk(12, 22, 1'b0, 0, 1, 1'b1, 32'h1));
        dispatch(mk(13, 23, 1'b0, 0, 1, 1'b1, 32'h1));
        push_exp(12, 32'hC2, 32'h1, cyc + 1);
        broadcast(0, 22, 32'hC2);
        push_exp(10, 32'hA0, 32'h1, cyc + 1);
        broadcast(0, 20, 32'hA0);
        // E lands in C's freed slot, below D in index but younger than D.
        dispatch(mk(14, 24, 1'b0, 0, 1, 1'b1, 32'h1));
        push_exp(13, 32'hD0, 32'h1, cyc + 1);
        push_exp(14, 32'hE0, 32'h1, cyc + 2);
        iq_if.wb_valid_in      = 2'b11;
        iq_if.wb_gpr_tag_in[0] = GPR_TAG_WIDTH'(23);
        iq_if.wb_data_in[0]    = 32'hD0;
        iq_if.wb_gpr_tag_in[1] = GPR_TAG_WIDTH'(24);
        iq_if.wb_data_in[1]    = 32'hE0;
        tick();
        iq_if.wb_valid_in = '0;
        drain("oldest");
        check_occ("oldest_b_remains", 1);
        do_flush();
        check_occ("oldest_after_flush", 0);
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) dispatch(mk(i, 30 + i, 1'b0, 0, 1, 1'b1, XLEN'(i)));
        check_ready("full", 1'b0);
        check_occ("full", 8);
        iq_if.dispatch_valid_in = 1'b1;
        iq_if.dispatch_entry_in = mk(20, 1, 1'b1, 32'd7, 2, 1'b1, 32'd8);
        push_exp(5, 32'h55, 32'd5, cyc + 1);
        broadcast(0, 35, 32'h55);
        check_ready("full_issue_cycle", 1'b0);
        tick();
        check_ready("full_after_issue", 1'b1);
        check_occ("full_after_issue", 7);
        push_exp(20, 32'd7, 32'd8, cyc + 1);
        tick();
        iq_if.dispatch_valid_in = 1'b0;
        drain("full");
        check_occ("full_refilled", 7);
        do_flush();
    endtask

    task automatic test_bypass();
        iq_if.dispatch_valid_in = 1'b1;
        iq_if.dispatch_entry_in = mk(6, 5, 1'b0, 0, 9, 1'b1, 32'd7);
        push_exp(6, 32'd42, 32'd7, cyc + 1);
        broadcast(0, 5, 32'd42);
        iq_if.dispatch_valid_in = 1'b0;
        drain("bypass");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            push_exp(24 + i, XLEN'(100 + i), XLEN'(200 + i), cyc + 1);
            dispatch(mk(24 + i, 1, 1'b1, XLEN'(100 + i), 2, 1'b1, XLEN'(200 + i)));
            check_occ("b2b_steady", 1);
        end
        tick();
        check_occ("b2b_empty", 0);
        drain("b2b");
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) dispatch(mk(15 + i, 40 + i, 1'b0, 0, 1, 1'b1, 32'h1));
        dispatch(mk(19, 1, 1'b1, 32'h3, 2, 1'b1, 32'h4));
        iq_if.flush_in          = 1'b1;
        iq_if.dispatch_valid_in = 1'b1;
        iq_if.dispatch_entry_in = mk(30, 1, 1'b1, 32'h5, 2, 1'b1, 32'h6);
        #1;
        checks++;
        if (iq_if.req_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_req_valid: got %b, required 0", iq_if.req_valid_out);
        end
        check_occ("flush_before", 5);
        tick();
        iq_if.flush_in          = 1'b0;
        iq_if.dispatch_valid_in = 1'b0;
        check_occ("flush_after", 0);
        check_ready("flush_after", 1'b1);
        broadcast(0, 40, 32'h9);
        iq_if.wb_valid_in = 2'b11;
        iq_if.wb_gpr_tag_in[0] = GPR_TAG_WIDTH'(41);
        iq_if.wb_gpr_tag_in[1] = GPR_TAG_WIDTH'(42);
        tick();
        iq_if.wb_valid_in = '0;
        broadcast(1, 43, 32'h9);
        repeat (3) tick();
        check_occ("flush_quiet", 0);
    endtask

    task automatic test_reset_mid();
        dispatch(mk(21, 50, 1'b0, 0, 1, 1'b1, 32'h1));
        dispatch(mk(22, 51, 1'b0, 0, 1, 1'b1, 32'h1));
        check_occ("rst_mid_before", 2);
        rst = 1'b1;
        #1;
        check_occ("rst_mid_async", 0);
        check_ready("rst_mid_async", 1'b1);
        tick();
        rst = 1'b0;
        iq_if.wb_valid_in      = 2'b11;
        iq_if.wb_gpr_tag_in[0] = GPR_TAG_WIDTH'(50);
        iq_if.wb_gpr_tag_in[1] = GPR_TAG_WIDTH'(51);
        tick();
        iq_if.wb_valid_in = '0;
        repeat (3) tick();
        check_occ("rst_mid_after", 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_issue();
        test_wakeup();
        test_oldest();
        test_full();
        test_bypass();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/supernova_alu_issue_queue.md
# supernova_alu_issue_queue

Issue queue feeding the Supernova ALU execution unit. It accepts renamed ALU micro-ops from dispatch, captures source operands from writeback broadcasts (data-capture scheme), and each cycle issues the oldest entry with both sources ready as a `req_valid`/`rs_entry_t` pair into the 1-cycle ALU. It sits between decode/rename dispatch and `supernova_alu_unit`, and snoops the writeback buses of all execution units.

## Interface
- `DEPTH`, default 8: number of queue entries. Must be at least 2.
- `NUM_WB`, default 2: number of writeback/wakeup broadcast ports.
- `clk`  in  1  Single clock. All state updates on the rising edge.
- `rst`  in  1  Reset, asynchronous, active-high.
- `dispatch_valid_in`  in  1  A dispatch entry is presented.
- `dispatch_entry_in`  in  `rs_entry_t`  Renamed micro-op: `instr`, `pc`, `src1/2_tag`, `src1/2_ready`, `src1/2_data`, `rd_phys_tag`, `rob_idx`.
- `dispatch_ready_out`  out  1  The queue can accept a dispatch this cycle.
- `wb_valid_in`  in  `NUM_WB`  Per-port broadcast valid.
- `wb_gpr_tag_in`  in  `NUM_WB` x `GPR_TAG_WIDTH`  Physical destination tag per port.
- `wb_data_in`  in  `NUM_WB` x `XLEN`  Result data per port.
- `flush_in`  in  1  Pipeline flush: discard all entries.
- `req_valid_out`  out  1  Issue valid to the ALU. The ALU never stalls.
- `req_entry_out`  out  `rs_entry_t`  Issued entry, with both sources' data filled in.
- `occupancy_out`  out  `$clog2(DEPTH+1)`  Number of valid entries.

## Operation
- **Per-entry state:**
  - `valid`
  - `rs_entry_t` payload
  - a row of the age matrix: `older[i][j]` = 1 means entry i was dispatched before entry j.
- **Dispatch:**
  - A dispatch is accepted when `dispatch_valid_in && dispatch_ready_out`.
  - It writes the lowest-index free entry and sets `valid`.
  - It sets `older[k][new]` = 1 for every valid k, and `older[new][*]` = 0.
  - `dispatch_ready_out` = (`occupancy` < `DEPTH`). It is computed from registered state only and ignores an issue in the same cycle.
- **Wakeup:**
  - For each valid entry and each source with ready = 0, any port p with `wb_valid_in[p]` and a matching tag sets ready = 1 and latches `wb_data_in[p]`.
  - Wakeup also applies to the entry being dispatched in the same cycle, so the captured operand is written together with the dispatch.
  - If several ports match the same tag, the lowest-index port wins. This is a protocol error, so an assertion fires.
- **Select:**
  - Candidate = valid && `src1_ready` && `src2_ready`.
  - The selected entry is the candidate with no older candidate.
  - `req_valid_out` = any candidate && !`flush_in`.
  - `req_entry_out` = the payload of the selected entry. Both are driven from registered state.
  - The issued entry's `valid` clears at the same edge, and its column in the age matrix is ignored from then on.
- **Flush:**
  - `flush_in` clears every `valid` at the edge.
  - A dispatch in a flush cycle is dropped.
  - The ALU sees no issue during a flush cycle.
- **Simultaneous dispatch and issue:** allowed in the same cycle; the occupancy change is +1 − 1 = 0.
- **Occupancy:** `occupancy_out` is a register updated by +dispatch − issue, and is forced to 0 on flush.

## Timing
- **Reset** (async, while `rst` is high):
  - all `valid` = 0, age matrix = 0, occupancy = 0
  - `req_valid_out` = 0, `dispatch_ready_out` = 1, `occupancy_out` = 0
  - `req_entry_out` = 0
- **Dispatch with both sources ready:** accepted at edge N, visible as a candidate in cycle N+1, issued in cycle N+1. The minimum dispatch-to-issue latency is 1 cycle.
- **Wakeup:** a broadcast in cycle c makes the entry a candidate in cycle c+1. There is no same-cycle wakeup-to-issue path.
- **Throughput:** at most one dispatch and one issue per cycle.
- **Full queue:** `dispatch_ready_out` = 0 for the whole cycle, even if an issue frees an entry in that cycle. It returns to 1 in the cycle after the issue.
- **Reset mid-operation:** all entries are lost immediately, and there is no issue from that point on.

## Structure
- **Shared in `supernova_pkg`:**
  - `rs_entry_t`, including the `src*_tag`, `src*_ready` and `src*_data` fields
  - `GPR_TAG_WIDTH`, `ROB_IDX_WIDTH`
  - the default `ALU_IQ_DEPTH`
- **Shared in `stu_pkg`:** `XLEN`.
- **Sub-module `supernova_oldest_ready_select`:** combinational, parameterised by `DEPTH`. Inputs are the candidate vector and the age matrix; outputs are a one-hot grant and `any`. It will be reused by the LSU and MDU queues.

## Test plan
1. **Reset and single issue:** assert `rst`, then dispatch ADDI with both sources ready and `rob_idx`=3. Required response: `req_valid_out`=1 exactly one cycle after acceptance with `rob_idx`=3; `occupancy_out` goes 1 → 0.
2. **Wakeup:** dispatch ADD with `src2_ready`=0 and `src2_tag`=17, then 3 idle cycles, then `wb_valid_in[1]`=1 with tag 17 and data 0xDEAD. Required response: issue in the next cycle with `src2_data`=0xDEAD; no issue before the broadcast.
3. **Oldest first:** dispatch A, B, C not ready, then wake C, then A in consecutive cycles. Required response: issue order C, A; B remains.
4. **Full queue:** dispatch 8 entries that are not ready. Required response: `dispatch_ready_out`=0 and `occupancy_out`=8. Wake one entry: it issues, and `dispatch_ready_out`=1 in the following cycle.
5. **Same-cycle dispatch bypass:** dispatch with `src1_tag`=5 not ready while tag 5 is broadcast with data 42 in the same cycle. Required response: issue next cycle with `src1_data`=42.
6. **Flush:** with 5 valid entries and one candidate, assert `flush_in` together with a dispatch. Required response: `req_valid_out`=0 in that cycle, then `occupancy_out`=0 and no issues afterwards.
